bcd_countdown_timer: RTL

Multi-digit BCD countdown timer: the decrementing counterpart of the team's decade up-counters. It loads a BCD preset, counts down one step per `tick` strobe under a start/pause/done state machine, and flags expiry. It sits beside the up-counting display and timekeeping blocks and drives the same BCD display path.

---
 rtl/bcd_timer_pkg.sv | 20 ++
 rtl/bcd_down_digit.sv | 30 +++
 rtl/bcd_countdown_timer.sv | 118 +++++++++++
 3 files changed

// File: rtl/bcd_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Used by the digit cells and the timer top level.
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int          BCD_W   = 4;
  localparam logic [3:0]  BCD_MAX = 4'd9;

  // Clamp an out-of-range nibble (10..15) to the largest decimal digit.
  function automatic logic [BCD_W-1:0] sanitize(input logic [BCD_W-1:0] n);
    return (n > BCD_MAX) ? BCD_MAX : n;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One decimal digit of a down-counting borrow chain.
// Wraps 0 -> 9 on decrement and requests a borrow from the next digit.
module bcd_down_digit
  import bcd_timer_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_in,
  input  logic             load,
  input  logic [BCD_W-1:0] load_digit,
  output logic [BCD_W-1:0] digit,
  output logic             borrow_out
);

  logic [BCD_W-1:0] r_digit;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_digit <= '0;
    end else if (load) begin
      r_digit <= load_digit;
    end else if (dec_in) begin
      r_digit <= (r_digit == '0) ? BCD_MAX : r_digit - 1'b1;
    end
  end

  assign digit      = r_digit;
  assign borrow_out = dec_in && (r_digit == '0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with IDLE/RUN/PAUSE/DONE control,
// expiry pulse and non-BCD preset flag.
module bcd_countdown_timer
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [BCD_W*DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    tick,
  output logic [BCD_W*DIGITS-1:0] count,
  output logic                    running,
  output logic                    done,
  output logic                    zero_pulse,
  output logic                    load_err
);

  localparam int W = BCD_W * DIGITS;

  state_t         r_state;
  state_t         w_state_next;
  logic           r_zero_pulse;
  logic           r_load_err;
  logic           w_zero_evt;
  logic           w_dec;
  logic           w_count_zero;
  logic           w_count_one;
  logic [DIGITS:0]  w_borrow;
  logic [DIGITS-1:0] w_bad;
  logic [W-1:0]   w_count;

  // A tick only counts in RUN and only when nothing of higher priority is present.
  assign w_dec       = (r_state == ST_RUN) && tick && !stop && !load;
  assign w_borrow[0] = w_dec;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_bad[gi] = (load_value[gi*BCD_W +: BCD_W] > BCD_MAX);

      bcd_down_digit u_digit (
        .clk        (clk),
        .reset      (reset),
        .dec_in     (w_borrow[gi]),
        .load       (load),
        .load_digit (sanitize(load_value[gi*BCD_W +: BCD_W])),
        .digit      (w_count[gi*BCD_W +: BCD_W]),
        .borrow_out (w_borrow[gi+1])
      );
    end
  endgenerate

  // "Next value is 0" is equivalent to the present value being exactly 1.
  assign w_count_zero = (w_count == '0);
  assign w_count_one  = (w_count == W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_zero_pulse <= 1'b0;
      r_load_err   <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_zero_pulse <= w_zero_evt;
      r_load_err   <= load && (|w_bad);
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_zero_evt   = 1'b0;
    if (load) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!stop && start) begin
            if (w_count_zero) begin
              w_state_next = ST_DONE;
              w_zero_evt   = 1'b1;
            end else begin
              w_state_next = ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (stop) begin
            w_state_next = ST_PAUSE;
          end else if (tick && w_count_one) begin
            w_state_next = ST_DONE;
            w_zero_evt   = 1'b1;
          end
        end
        ST_PAUSE: begin
          if (!stop && start) begin
            w_state_next = ST_RUN;
          end
        end
        ST_DONE: begin
          w_state_next = ST_DONE;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign count      = w_count;
  assign running    = (r_state == ST_RUN);
  assign done       = (r_state == ST_DONE);
  assign zero_pulse = r_zero_pulse;
  assign load_err   = r_load_err;

endmodule
